// File: rtl/ram_burst_wr_arbiter.sv
// ram_burst_wr_arbiter: round-robin whole-burst arbiter for the ring-buffer RAM write port.
// Grants only bursts that fit, drives the circular write address and publishes a delayed commit pointer.
module ram_burst_wr_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 48,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              req_valid_i,
    input  logic [2*LEN_WIDTH-1:0]  req_len_i,
    output logic [1:0]              req_ready_o,
    input  logic [1:0]              beat_valid_i,
    input  logic [2*DATA_WIDTH-1:0] beat_data_i,
    output logic [1:0]              beat_ready_o,
    output logic                    ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wr_data_o,
    input  logic [ADDR_WIDTH:0]     rd_ptr_i,
    output logic [ADDR_WIDTH:0]     commit_ptr_o,
    output logic                    busy_o,
    output logic                    owner_o
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int CW = PW + LEN_WIDTH;
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, commit_q, commit_d, free;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d, len0, len1, sel_len;
    logic                  owner_q, owner_d, last_q, last_d, pend_q, pend_d;
    logic                  sel, beat_hs, wen_q;
    logic [1:0]            elig, grant;
    logic [DATA_WIDTH-1:0] beat, data_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    assign len0    = req_len_i[0 +: LEN_WIDTH];
    assign len1    = req_len_i[LEN_WIDTH +: LEN_WIDTH];
    assign free    = DEPTH - (wr_ptr_q - rd_ptr_i);
    assign elig    = {req_valid_i[1] && (CW'(len1) <= CW'(free)),
                      req_valid_i[0] && (CW'(len0) <= CW'(free))};
    assign grant   = &elig ? (last_q ? 2'b01 : 2'b10) : elig;
    assign req_ready_o  = (state_q == IDLE && rst_ni) ? grant : 2'b00;
    assign sel     = grant[1];
    assign sel_len = sel ? len1 : len0;
    assign beat_ready_o = (state_q == BURST) ? {owner_q, ~owner_q} : 2'b00;
    assign beat_hs = |(beat_ready_o & beat_valid_i);
    assign beat    = owner_q ? beat_data_i[DATA_WIDTH +: DATA_WIDTH] : beat_data_i[0 +: DATA_WIDTH];

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rem_d    = rem_q;
        owner_d  = owner_q;
        last_d   = last_q;
        pend_d   = beat_hs && rem_q == LEN_WIDTH'(1);
        // commit lags the final RAM write by one cycle so the read side never sees an unsettled word
        commit_d = pend_q ? wr_ptr_q : commit_q;
        if (state_q == IDLE && |req_ready_o) begin
            last_d = sel;
            if (sel_len != '0) begin
                owner_d = sel;
                rem_d   = sel_len;
                state_d = BURST;
            end
        end
        if (beat_hs) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rem_d    = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            commit_q <= '0;
            rem_q    <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            pend_q   <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            commit_q <= commit_d;
            rem_q    <= rem_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            wen_q    <= beat_hs;
            if (beat_hs) begin
                addr_q <= wr_ptr_q[ADDR_WIDTH-1:0];
                data_q <= beat;
            end
        end
    end

    assign ram_wr_en_o   = wen_q;
    assign ram_wr_addr_o = addr_q;
    assign ram_wr_data_o = data_q;
    assign commit_ptr_o  = commit_q;
    assign busy_o        = state_q == BURST;
    assign owner_o       = owner_q;
endmodule

// File: tb/tb_ram_burst_wr_arbiter.sv
// tb_ram_burst_wr_arbiter: directed bench for ram_burst_wr_arbiter with hand-computed expectations.
module tb_ram_burst_wr_arbiter;
    localparam int AW = 10;
    localparam int DW = 48;
    localparam int LW = 8;
    localparam int PW = AW + 1;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [1:0]      req_valid_i = '0;
    logic [2*LW-1:0] req_len_i = '0;
    logic [1:0]      req_ready_o;
    logic [1:0]      beat_valid_i = '0;
    logic [2*DW-1:0] beat_data_i = '0;
    logic [1:0]      beat_ready_o;
    logic            ram_wr_en_o;
    logic [AW-1:0]   ram_wr_addr_o;
    logic [DW-1:0]   ram_wr_data_o;
    logic [PW-1:0]   rd_ptr_i = '0;
    logic [PW-1:0]   commit_ptr_o;
    logic            busy_o;
    logic            owner_o;

    ram_burst_wr_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_len_i(req_len_i), .req_ready_o(req_ready_o),
        .beat_valid_i(beat_valid_i), .beat_data_i(beat_data_i), .beat_ready_o(beat_ready_o),
        .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
        .rd_ptr_i(rd_ptr_i), .commit_ptr_o(commit_ptr_o), .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            gnt_q[$];
    logic [PW-1:0] cm_q[$];
    logic [PW-1:0] cm_last = '0;
    int busy_cyc = 0;
    int rr0_cyc = 0;
    bit watch_br0 = 0;
    bit br0_bad = 0;

    always @(negedge clk_i) begin
        if (ram_wr_en_o) begin
            wa_q.push_back(ram_wr_addr_o);
            wd_q.push_back(ram_wr_data_o);
        end
        for (int i = 0; i < 2; i++) if (req_valid_i[i] && req_ready_o[i]) gnt_q.push_back(i);
        if (commit_ptr_o != cm_last) begin
            cm_q.push_back(commit_ptr_o);
            cm_last = commit_ptr_o;
        end
        if (busy_o) busy_cyc++;
        if (req_ready_o[0]) rr0_cyc++;
        if (watch_br0 && beat_ready_o[0]) br0_bad = 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic send_req(input int lane, input int len);
        bit ok;
        ok = 0;
        req_valid_i[lane] = 1'b1;
        req_len_i[lane*LW +: LW] = LW'(len);
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk_i);
            ok = req_ready_o[lane];
            tick();
        end
        req_valid_i[lane] = 1'b0;
        if (!ok) chk("req_timeout", 0, 1);
    endtask

    task automatic send_beats(input int lane, input int n, input logic [DW-1:0] base, input int gap);
        bit ok;
        for (int k = 0; k < n; k++) begin
            if (k > 0) repeat (gap) tick();
            ok = 0;
            beat_valid_i[lane] = 1'b1;
            beat_data_i[lane*DW +: DW] = base + DW'(k);
            for (int c = 0; c < 300 && !ok; c++) begin
                @(negedge clk_i);
                ok = beat_ready_o[lane];
                tick();
            end
            beat_valid_i[lane] = 1'b0;
            if (!ok) chk("beat_timeout", 0, 1);
        end
    endtask

    initial begin
        // reset state, with requests and beats asserted to show nothing leaks out
        req_valid_i = 2'b11;
        req_len_i = {8'd1, 8'd1};
        beat_valid_i = 2'b11;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_beat_ready", beat_ready_o, 0);
        chk("rst_wr_en", ram_wr_en_o, 0);
        chk("rst_addr", ram_wr_addr_o, 0);
        chk("rst_data", ram_wr_data_o, 0);
        chk("rst_commit", commit_ptr_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_owner", owner_o, 0);
        req_valid_i = '0;
        beat_valid_i = '0;
        tick();
        rst_ni = 1'b1;
        tick();

        // single lane 0 burst of 4
        rr0_cyc = 0;
        send_req(0, 4);
        send_beats(0, 4, 48'hA, 0);
        @(negedge clk_i);
        chk("t1_last_wr_en", ram_wr_en_o, 1);
        chk("t1_commit_early", commit_ptr_o, 0);
        @(negedge clk_i);
        chk("t1_commit", commit_ptr_o, 4);
        chk("t1_wr_en_off", ram_wr_en_o, 0);
        chk("t1_rr0_pulses", rr0_cyc, 1);
        chk("t1_nwr", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) if (i < wa_q.size()) begin
            chk("t1_addr", wa_q[i], i);
            chk("t1_data", wd_q[i], 48'hA + i);
        end

        // both lanes competing, round robin
        do_reset();
        wa_q.delete(); wd_q.delete(); gnt_q.delete(); cm_q.delete();
        req_len_i = {8'd2, 8'd2};
        beat_data_i = {48'h200, 48'h100};
        beat_valid_i = 2'b11;
        req_valid_i = 2'b11;
        for (int c = 0; c < 100 && gnt_q.size() < 4; c++) @(posedge clk_i);
        #1 req_valid_i = '0;
        repeat (10) tick();
        beat_valid_i = '0;
        chk("t2_ngnt", gnt_q.size(), 4);
        for (int i = 0; i < 4; i++) if (i < gnt_q.size()) chk("t2_gnt", gnt_q[i], i % 2);
        chk("t2_nwr", wa_q.size(), 8);
        for (int i = 0; i < 8; i++) if (i < wa_q.size()) begin
            chk("t2_addr", wa_q[i], i);
            chk("t2_data", wd_q[i], ((i / 2) % 2) ? 48'h200 : 48'h100);
        end
        chk("t2_ncommit", cm_q.size(), 4);
        for (int i = 0; i < 4; i++) if (i < cm_q.size()) chk("t2_commit", cm_q[i], 2 * (i + 1));

        // fill ring to 1020, then a burst that must wait for space and wraps
        do_reset();
        for (int b = 0; b < 4; b++) begin
            send_req(0, 255);
            send_beats(0, 255, 48'h0, 0);
        end
        repeat (3) tick();
        chk("t3_commit_fill", commit_ptr_o, 1020);
        wa_q.delete(); wd_q.delete();
        rr0_cyc = 0;
        req_len_i[0 +: LW] = 8'd8;
        req_valid_i[0] = 1'b1;
        repeat (6) tick();
        chk("t3_blocked", rr0_cyc, 0);
        rd_ptr_i = 11'd8;
        send_req(0, 8);
        send_beats(0, 8, 48'h500, 0);
        repeat (3) tick();
        chk("t3_nwr", wa_q.size(), 8);
        for (int i = 0; i < 8; i++) if (i < wa_q.size()) begin
            chk("t3_addr", wa_q[i], (1020 + i) % 1024);
            chk("t3_data", wd_q[i], 48'h500 + i);
        end
        chk("t3_commit_wrap", commit_ptr_o, 11'h404);

        // lane 0 too large, lane 1 fits and must not be blocked
        wa_q.delete(); wd_q.delete();
        rr0_cyc = 0;
        beat_data_i[0 +: DW] = 48'hBAD;
        beat_valid_i[0] = 1'b1;
        watch_br0 = 1;
        req_len_i = {8'd1, 8'd16};
        req_valid_i = 2'b11;
        @(negedge clk_i);
        chk("t4_ready", req_ready_o, 2'b10);
        tick();
        req_valid_i[1] = 1'b0;
        send_beats(1, 1, 48'h77, 0);
        repeat (3) tick();
        watch_br0 = 0;
        chk("t4_br0_never", br0_bad, 0);
        chk("t4_lane0_waits", rr0_cyc, 0);
        chk("t4_owner", owner_o, 1);
        chk("t4_nwr", wa_q.size(), 1);
        if (wa_q.size() > 0) begin
            chk("t4_addr", wa_q[0], 4);
            chk("t4_data", wd_q[0], 48'h77);
        end
        chk("t4_commit", commit_ptr_o, 1029);
        req_valid_i = '0;
        beat_valid_i = '0;

        // gapped burst of 3
        rd_ptr_i = 11'd1029;
        wa_q.delete(); wd_q.delete();
        busy_cyc = 0;
        send_req(0, 3);
        send_beats(0, 3, 48'h30, 2);
        repeat (3) tick();
        chk("t5_busy_cycles", busy_cyc, 7);
        chk("t5_nwr", wa_q.size(), 3);
        for (int i = 0; i < 3; i++) if (i < wa_q.size()) begin
            chk("t5_addr", wa_q[i], 5 + i);
            chk("t5_data", wd_q[i], 48'h30 + i);
        end
        chk("t5_commit", commit_ptr_o, 1032);

        // zero-length request
        wa_q.delete(); wd_q.delete();
        rr0_cyc = 0;
        send_req(0, 0);
        repeat (4) tick();
        chk("t5_len0_ready", rr0_cyc, 1);
        chk("t5_len0_nwr", wa_q.size(), 0);
        chk("t5_len0_commit", commit_ptr_o, 1032);
        chk("t5_len0_busy", busy_o, 0);

        // asynchronous reset in the middle of a burst
        rd_ptr_i = 11'd1032;
        send_req(0, 5);
        send_beats(0, 2, 48'h60, 0);
        rst_ni = 1'b0;
        #1;
        chk("t6_wr_en", ram_wr_en_o, 0);
        chk("t6_addr", ram_wr_addr_o, 0);
        chk("t6_data", ram_wr_data_o, 0);
        chk("t6_commit", commit_ptr_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_owner", owner_o, 0);
        chk("t6_beat_ready", beat_ready_o, 0);
        chk("t6_req_ready", req_ready_o, 0);
        rd_ptr_i = '0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        wa_q.delete(); wd_q.delete();
        send_req(1, 1);
        send_beats(1, 1, 48'hC1, 0);
        repeat (3) tick();
        chk("t6_nwr", wa_q.size(), 1);
        if (wa_q.size() > 0) begin
            chk("t6_post_addr", wa_q[0], 0);
            chk("t6_post_data", wd_q[0], 48'hC1);
        end
        chk("t6_post_commit", commit_ptr_o, 1);
        chk("t6_post_owner", owner_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
